// File: rtl/fetch_pkg.sv
// Shared types and constants for the Dioptase fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned EXC_W = 8;
    localparam int unsigned CNT_W = 16;

    localparam logic [EXC_W-1:0] FEXC_NONE  = 8'h00;
    localparam logic [EXC_W-1:0] FEXC_ITLB  = 8'h82;
    localparam logic [EXC_W-1:0] FEXC_ALIGN = 8'h83;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic             valid;
        logic [EXC_W-1:0] exc;
    } fetch_slot_t;

    // Misalignment outranks an ITLB miss for the issued address.
    function automatic logic [EXC_W-1:0] issue_exc(input logic [XLEN-1:0] addr,
                                                   input logic            miss);
        if (addr[1:0] != 2'b00) return FEXC_ALIGN;
        if (miss)               return FEXC_ITLB;
        return FEXC_NONE;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port plus the decode-facing fetch result.
interface fetch_stage_if;
    import fetch_pkg::*;

    logic [XLEN-1:0]  mem_addr;
    logic             mem_re;
    logic             itlb_miss;
    logic [XLEN-1:0]  pc_out;
    logic             bubble_out;
    logic [EXC_W-1:0] tlb_exc_out;

    modport master (
        output mem_addr, mem_re, pc_out, bubble_out, tlb_exc_out,
        input  itlb_miss
    );

    modport slave (
        input  mem_addr, mem_re, pc_out, bubble_out, tlb_exc_out,
        output itlb_miss
    );

endinterface

// File: rtl/fetch_stage_next_pc_sel.sv
// Priority mux for the next fetch PC: exception > return > branch > sequential.
module next_pc_sel
    import fetch_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            exc_redirect,
    input  logic [XLEN-1:0] exc_target,
    input  logic            ret_redirect,
    input  logic [XLEN-1:0] ret_target,
    input  logic            br_redirect,
    input  logic [XLEN-1:0] br_target,
    output logic [XLEN-1:0] next_pc_c,
    output logic            redirect_c
);

    always_comb begin
        next_pc_c  = pc + XLEN'(4);
        redirect_c = exc_redirect | ret_redirect | br_redirect;
        if (exc_redirect)      next_pc_c = exc_target;
        else if (ret_redirect) next_pc_c = ret_target;
        else if (br_redirect)  next_pc_c = br_target;
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch PC generation and two-slot tracking across the fixed two-cycle imem latency.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0400
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             halt,
    input  logic             stall,
    input  logic             exc_redirect,
    input  logic [XLEN-1:0]  exc_target,
    input  logic             ret_redirect,
    input  logic [XLEN-1:0]  ret_target,
    input  logic             br_redirect,
    input  logic [XLEN-1:0]  br_target,
    output logic [CNT_W-1:0] redirect_cnt,
    fetch_stage_if.master    fif
);

    localparam fetch_slot_t SLOT_RST = '{pc: RESET_PC, valid: 1'b0, exc: FEXC_NONE};

    logic [XLEN-1:0]  pc_q;
    fetch_slot_t      slot_a_q, slot_b_q;
    fetch_slot_t      slot_a_d, slot_b_d;
    logic [XLEN-1:0]  pc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  next_pc_c;
    logic             redirect_c;
    logic             en_c;

    assign en_c = clk_en & ~halt;

    next_pc_sel u_next_pc_sel (
        .pc           (pc_q),
        .exc_redirect (exc_redirect),
        .exc_target   (exc_target),
        .ret_redirect (ret_redirect),
        .ret_target   (ret_target),
        .br_redirect  (br_redirect),
        .br_target    (br_target),
        .next_pc_c    (next_pc_c),
        .redirect_c   (redirect_c)
    );

    // A redirect squashes both slots and loads the PC even while stalled.
    always_comb begin
        pc_d     = pc_q;
        slot_a_d = slot_a_q;
        slot_b_d = slot_b_q;
        if (!stall) begin
            pc_d     = next_pc_c;
            slot_b_d = slot_a_q;
            slot_a_d = '{pc: pc_q, valid: 1'b1, exc: issue_exc(pc_q, fif.itlb_miss)};
        end else if (redirect_c) begin
            pc_d = next_pc_c;
        end
        if (redirect_c) begin
            slot_a_d.valid = 1'b0;
            slot_b_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            slot_a_q <= SLOT_RST;
            slot_b_q <= SLOT_RST;
            cnt_q    <= '0;
        end else if (en_c) begin
            pc_q     <= pc_d;
            slot_a_q <= slot_a_d;
            slot_b_q <= slot_b_d;
            if (redirect_c && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign redirect_cnt    = cnt_q;
    assign fif.mem_addr    = pc_q;
    assign fif.mem_re      = rst_n & ~halt;
    assign fif.pc_out      = slot_b_q.pc;
    assign fif.bubble_out  = ~slot_b_q.valid;
    assign fif.tlb_exc_out = slot_b_q.valid ? slot_b_q.exc : FEXC_NONE;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scenarios plus random stimulus against a queue-based in-flight fetch model.
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'h0000_0400;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en, halt, stall;
    logic        exc_redirect, ret_redirect, br_redirect;
    logic [31:0] exc_target, ret_target, br_target;
    logic [15:0] redirect_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    fetch_stage_if fif ();

    fetch_stage #(.RESET_PC(RPC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clk_en       (clk_en),
        .halt         (halt),
        .stall        (stall),
        .exc_redirect (exc_redirect),
        .exc_target   (exc_target),
        .ret_redirect (ret_redirect),
        .ret_target   (ret_target),
        .br_redirect  (br_redirect),
        .br_target    (br_target),
        .redirect_cnt (redirect_cnt),
        .fif          (fif)
    );

    always #5 clk = ~clk;

    // Model: in-flight fetches as a queue; the oldest entry is what decode sees.
    typedef struct {
        logic [31:0] pc;
        bit          v;
        logic [7:0]  exc;
    } rec_t;

    rec_t        q[$];
    logic [31:0] m_pc;
    int unsigned m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        rec_t r;
        r.pc = RPC; r.v = 1'b0; r.exc = 8'h00;
        q.delete();
        q.push_back(r);
        q.push_back(r);
        m_pc  = RPC;
        m_cnt = 0;
    endfunction

    function automatic void m_edge();
        bit          redir;
        logic [31:0] tgt;
        rec_t        r;
        if (!clk_en || halt) return;
        redir = exc_redirect || ret_redirect || br_redirect;
        tgt   = exc_redirect ? exc_target : ret_redirect ? ret_target : br_target;
        if (!stall) begin
            r.pc  = m_pc;
            r.v   = 1'b1;
            r.exc = (m_pc % 4 != 0) ? 8'h83 : fif.itlb_miss ? 8'h82 : 8'h00;
            q.push_back(r);
            void'(q.pop_front());
            m_pc = redir ? tgt : m_pc + 32'd4;
        end else if (redir) begin
            m_pc = tgt;
        end
        if (redir) begin
            foreach (q[i]) q[i].v = 1'b0;
            if (m_cnt < 65535) m_cnt++;
        end
    endfunction

    task automatic check_all();
        chk("mem_addr", fif.mem_addr, m_pc);
        chk("mem_re", 32'(fif.mem_re), 32'(rst_n && !halt));
        chk("bubble_out", 32'(fif.bubble_out), 32'(!q[0].v));
        chk("tlb_exc_out", 32'(fif.tlb_exc_out), q[0].v ? 32'(q[0].exc) : 32'd0);
        chk("redirect_cnt", 32'(redirect_cnt), m_cnt);
        if (q[0].v) chk("pc_out", fif.pc_out, q[0].pc);
    endtask

    task automatic step();
        m_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        clk_en = 1'b1; halt = 1'b0; stall = 1'b0;
        exc_redirect = 1'b0; ret_redirect = 1'b0; br_redirect = 1'b0;
        exc_target = '0; ret_target = '0; br_target = '0;
        fif.itlb_miss = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        idle();
        #12;
        m_reset();
        check_all();
        chk("rst_pc_out", fif.pc_out, RPC);
        @(negedge clk) rst_n = 1'b1;
        #1 check_all();

        // Start-up sequence.
        step(); chk("seq_addr1", fif.mem_addr, 32'h404);
        step(); chk("seq_addr2", fif.mem_addr, 32'h408);
        chk("first_pc", fif.pc_out, 32'h400);
        chk("first_valid", 32'(fif.bubble_out), 32'd0);
        step(); step();

        // Stall held three cycles.
        stall = 1'b1;
        repeat (3) step();
        stall = 1'b0;

        n = 0;
        while (m_pc != 32'h410 && n < 20) begin step(); n++; end
        chk("reach_410", fif.mem_addr, 32'h410);

        // Taken branch: two bubbles then the target stream.
        br_redirect = 1'b1; br_target = 32'h1000;
        step();
        idle();
        chk("br_bubble1", 32'(fif.bubble_out), 32'd1);
        chk("br_cnt", 32'(redirect_cnt), 32'd1);
        step(); chk("br_bubble2", 32'(fif.bubble_out), 32'd1);
        step(); chk("br_tgt", fif.pc_out, 32'h1000);
        step(); chk("br_tgt4", fif.pc_out, 32'h1004);

        // Exception beats branch, and overrides stall for the squash.
        exc_redirect = 1'b1; exc_target = 32'h20;
        br_redirect = 1'b1; br_target = 32'h1000; stall = 1'b1;
        step();
        idle();
        chk("exc_addr", fif.mem_addr, 32'h20);
        chk("exc_squash", 32'(fif.bubble_out), 32'd1);
        chk("exc_cnt", 32'(redirect_cnt), 32'd2);
        step(); step();
        chk("exc_tgt", fif.pc_out, 32'h20);

        // ITLB miss, then misaligned return target.
        br_redirect = 1'b1; br_target = 32'h800;
        step();
        idle();
        fif.itlb_miss = 1'b1;
        step();
        fif.itlb_miss = 1'b0;
        step();
        chk("itlb_pc", fif.pc_out, 32'h800);
        chk("itlb_exc", 32'(fif.tlb_exc_out), 32'h82);
        ret_redirect = 1'b1; ret_target = 32'h802;
        step();
        idle();
        step(); step();
        chk("align_pc", fif.pc_out, 32'h802);
        chk("align_exc", 32'(fif.tlb_exc_out), 32'h83);

        // Async reset in the middle of a redirect bubble.
        br_redirect = 1'b1; br_target = 32'h3000;
        step();
        idle();
        #2 rst_n = 1'b0;
        #1 m_reset();
        check_all();
        chk("arst_pc_out", fif.pc_out, RPC);
        @(negedge clk) rst_n = 1'b1;

        // Wrap-around at the top of the address space.
        br_redirect = 1'b1; br_target = 32'hFFFF_FFFC;
        step();
        idle();
        step(); chk("wrap_addr", fif.mem_addr, 32'h0);
        step(); chk("wrap_pc", fif.pc_out, 32'hFFFF_FFFC);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            clk_en        = ($urandom_range(0, 9) != 0);
            halt          = ($urandom_range(0, 19) == 0);
            stall         = ($urandom_range(0, 4) == 0);
            exc_redirect  = ($urandom_range(0, 24) == 0);
            ret_redirect  = ($urandom_range(0, 19) == 0);
            br_redirect   = ($urandom_range(0, 11) == 0);
            exc_target    = $urandom() & 32'hFFFF_FFFC;
            ret_target    = $urandom() & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            br_target     = $urandom() & 32'hFFFF_FFFC;
            fif.itlb_miss = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Front-end stage of the Dioptase pipeline. It generates the fetch PC, drives the instruction-memory read port, and tracks the two fetches in flight across the fixed two-cycle memory latency. It hands decode a PC, a bubble flag and a fetch-exception code that line up with the instruction word arriving on `mem_out_0`. Redirects (exception entry, `rfe`/`rfi` return, taken branch) are handled here by squashing in-flight fetches.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0400: first fetch address after reset.

Ports:
- `clk` in 1: the single pipeline clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `clk_en` in 1: global clock enable. When low, no state changes.
- `halt` in 1: when high, no state changes (same as `clk_en` low).
- `stall` in 1: decode/back-end stall. Holds PC and both slots.
- `exc_redirect` in 1, `exc_target` in 32: exception/interrupt entry from writeback.
- `ret_redirect` in 1, `ret_target` in 32: `rfe`/`rfi` return (EPC) from writeback.
- `br_redirect` in 1, `br_target` in 32: taken branch from execute.
- `itlb_miss` in 1: ITLB miss for the address currently on `mem_addr`. Valid in the issue cycle.
- `mem_addr` out 32: instruction read address.
- `mem_re` out 1: read enable.
- `pc_out` out 32: PC of the word currently on `mem_out_0`.
- `bubble_out` out 1: the word on `mem_out_0` is not a valid instruction.
- `tlb_exc_out` out 8: fetch exception code for the `pc_out` instruction. 0 means none.
- `redirect_cnt` out 16: saturating count of squashing redirects, for the perf bench.

## Operation
- Slots: A holds the fetch issued last cycle; B holds the fetch whose data is on `mem_out_0` now. Each slot carries pc, valid and exc.
- Normal advance, when `clk_en && !halt && !stall`:
  - B <= A.
  - A <= {`mem_addr`, 1, issue exc}.
  - PC <= next PC.
- Issue exc: 8'h83 if `mem_addr[1:0] != 0`, else 8'h82 if `itlb_miss`, else 0.
- Next-PC priority: `exc_redirect` > `ret_redirect` > `br_redirect` > PC+4. Arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0.
- Any redirect, in a non-halted, enabled cycle:
  - PC <= target.
  - A.valid <= 0 and B.valid <= 0, regardless of `stall`. Redirect overrides stall for the slot-valid bits only; PC still loads.
  - `redirect_cnt` += 1, saturating at 16'hFFFF.
- Stall without redirect: PC, A and B hold. `mem_addr` is held constant, so the memory re-returns the same word.
- `mem_re` = `rst_n && !halt`.
- Output mapping:
  - `pc_out` = B.pc.
  - `bubble_out` = !B.valid.
  - `tlb_exc_out` = B.valid ? B.exc : 0.
- A faulting fetch (exc != 0) still advances with valid = 1. Decode raises the exception, and writeback later issues `exc_redirect`.

## Timing
- Reset (async assert, sync release):
  - PC = `RESET_PC`.
  - A.valid = B.valid = 0. A/B pc = `RESET_PC`. A/B exc = 0.
  - `redirect_cnt` = 0.
  - Resulting outputs: `pc_out` = `RESET_PC`, `bubble_out` = 1, `tlb_exc_out` = 0, `mem_addr` = `RESET_PC`.
- The first valid instruction reaches decode on the 2nd enabled, unstalled edge after reset release.
- Latency: address issued at edge N has `pc_out`/`bubble_out=0` after edge N+2.
- Redirect at edge N:
  - `mem_addr` = target after edge N.
  - Two bubbles follow (after edges N and N+1).
  - Target instruction is valid after edge N+2.
- Back-to-back redirects: the later one wins, and the bubble window restarts.
- Simultaneous redirect sources: only the highest-priority target is used. The counter increments by 1.
- Reset asserted mid-redirect or mid-stall: all state returns to reset values immediately.

## Structure
- Shared package `fetch_pkg`:
  - `fetch_slot_t` struct {pc, valid, exc}.
  - Constants `FEXC_NONE`=8'h00, `FEXC_ITLB`=8'h82, `FEXC_ALIGN`=8'h83.
- One sub-module: `next_pc_sel`, the combinational priority mux producing the target and a redirect flag.

## Test plan
- Reset release with no stall:
  - `mem_addr` sequence is 0x400, 0x404, 0x408.
  - `pc_out` 0x400 appears with `bubble_out=0` after the 2nd edge.
- Stall held 3 cycles mid-stream: `mem_addr`, `pc_out` and `bubble_out` are constant throughout. The sequence then resumes with no lost or duplicated PC.
- `br_redirect` to 0x1000 at PC 0x410: exactly 2 bubbles, then `pc_out`=0x1000, then 0x1004; `redirect_cnt`=1.
- `exc_redirect` (0x20) and `br_redirect` (0x1000) in the same cycle, also with `stall`=1: next `mem_addr`=0x20, both slots squashed, `redirect_cnt` +1.
- `itlb_miss` on issue of 0x800: when `pc_out`=0x800, `tlb_exc_out`=8'h82. `ret_redirect` to 0x802 yields `tlb_exc_out`=8'h83 two cycles later.
- Async `rst_n` pulse during a redirect bubble: outputs return to reset values immediately. 32'hFFFF_FFFC fetches sequentially to 0x0.
